// File: rtl/fsm_serial_tx.sv
// fsm_serial_tx: start/data/parity/stop serial frame transmitter.
// Takes a parallel word over valid/ready and shifts it out LSB-first, framed
// by a low start bit, an optional odd-parity bit and a high stop bit.
// Every output is a flop. The next value of each output is decoded from the
// next state, so the line changes on the same edge as the state register.
module fsm_serial_tx #(
   parameter int DATA_W    = 8,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out,
   output logic              busy,
   output logic              done
);

   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   // One step of the running parity. The accumulator is seeded with 1, which
   // makes the final value the odd-parity bit.
   function automatic logic par_step(input logic acc, input logic data_bit);
      return acc ^ data_bit;
   endfunction

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                par_q, par_d;
   logic                out_q, out_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                accept_s;

   // A word is taken only while the registered ready flag is high. That flag
   // is high in IDLE and STOP, so a new frame can follow a stop bit with no gap.
   assign accept_s = in_valid && ready_q;

   // Next-state and datapath update for the frame sequencer.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               sh_d    = in_data;
               par_d   = 1'b1;
               cnt_d   = CNT_ZERO;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            state_d = ST_DATA;
         end
         ST_DATA: begin
            sh_d  = {1'b0, sh_q[DATA_W-1:1]};
            par_d = par_step(par_q, sh_q[0]);
            if (cnt_q == CNT_LAST) begin
               cnt_d = CNT_ZERO;
               if (PARITY_EN) begin
                  state_d = ST_PARITY;
               end else begin
                  state_d = ST_STOP;
               end
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            state_d = ST_STOP;
         end
         ST_STOP: begin
            if (accept_s) begin
               sh_d    = in_data;
               par_d   = 1'b1;
               cnt_d   = CNT_ZERO;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore output decode of the next state, so outputs can be flops.
   always_comb begin
      out_d   = 1'b1;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      case (state_d)
         ST_IDLE: begin
            out_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
         ST_START: begin
            out_d = 1'b0;
         end
         ST_DATA: begin
            out_d = sh_d[0];
         end
         ST_PARITY: begin
            out_d = par_d;
         end
         ST_STOP: begin
            out_d   = 1'b1;
            ready_d = 1'b1;
            done_d  = 1'b1;
         end
         default: begin
            out_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers. Reset drops any frame in flight
   // and forces the line high immediately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         sh_q    <= {DATA_W{1'b0}};
         cnt_q   <= CNT_ZERO;
         par_q   <= 1'b0;
         out_q   <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         out_q   <= out_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign in_ready = ready_q;
   assign out      = out_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_fsm_serial_tx.sv
// Directed bench for fsm_serial_tx: one instance with default parameters and
// one with the parity bit disabled, both sharing clock and reset.
module tb_fsm_serial_tx;

   logic       clk;
   logic       resetn;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out;
   logic       busy;
   logic       done;

   logic       np_valid;
   logic [7:0] np_data;
   logic       np_ready;
   logic       np_out;
   logic       np_busy;
   logic       np_done;

   int errors = 0;
   int checks = 0;

   fsm_serial_tx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out(out), .busy(busy), .done(done)
   );

   fsm_serial_tx #(.DATA_W(8), .PARITY_EN(1'b0)) dut_np (
      .clk(clk), .resetn(resetn), .in_valid(np_valid), .in_data(np_data),
      .in_ready(np_ready), .out(np_out), .busy(np_busy), .done(np_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Send one word on the default instance and compare all 11 frame cycles.
   task automatic send_frame(input logic [7:0] data, input logic [10:0] exp, input string name);
      int   waits = 0;
      logic exp_done;
      while (in_ready !== 1'b1 && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready: in_ready=%b expected 1", name, in_ready);
      end
      in_valid = 1'b1;
      in_data  = data;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 11; k++) begin
         exp_done = (k == 10);
         checks++;
         if (out !== exp[10-k]) begin
            errors++;
            $display("FAIL %s_out[%0d]: out=%b expected %b", name, k, out, exp[10-k]);
         end
         checks++;
         if ({busy, done} !== {1'b1, exp_done}) begin
            errors++;
            $display("FAIL %s_status[%0d]: busy,done=%b%b expected 1%b", name, k, busy, done, exp_done);
         end
         @(posedge clk); #1;
      end
      checks++;
      if ({out, in_ready, busy, done} !== 4'b1100) begin
         errors++;
         $display("FAIL %s_after: out,rdy,busy,done=%b expected 1100", name, {out, in_ready, busy, done});
      end
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      np_valid = 1'b0;
      np_data  = 8'h00;
      #12;
      checks++;
      if ({out, in_ready, busy, done} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_hold: out,rdy,busy,done=%b expected 1100", {out, in_ready, busy, done});
      end
      checks++;
      if ({np_out, np_ready, np_busy, np_done} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_hold_np: out,rdy,busy,done=%b expected 1100", {np_out, np_ready, np_busy, np_done});
      end
      @(negedge clk);
      resetn = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({out, in_ready, busy, done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_idle[%0d]: out,rdy,busy,done=%b expected 1100", c, {out, in_ready, busy, done});
         end
      end
   endtask

   task automatic test_single_frame();
      send_frame(8'hA5, 11'b01010010111, "single_a5");
   endtask

   task automatic test_parity();
      send_frame(8'h00, 11'b00000000011, "par_00");
      send_frame(8'h01, 11'b01000000001, "par_01");
      send_frame(8'hFF, 11'b01111111111, "par_ff");
   endtask

   task automatic test_no_parity();
      logic [9:0] exp;
      logic       exp_done;
      exp = 10'b0010110101;
      np_valid = 1'b1;
      np_data  = 8'h5A;
      @(posedge clk); #1;
      np_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         exp_done = (k == 9);
         checks++;
         if (np_out !== exp[9-k]) begin
            errors++;
            $display("FAIL nopar_out[%0d]: out=%b expected %b", k, np_out, exp[9-k]);
         end
         checks++;
         if ({np_busy, np_done} !== {1'b1, exp_done}) begin
            errors++;
            $display("FAIL nopar_status[%0d]: busy,done=%b%b expected 1%b", k, np_busy, np_done, exp_done);
         end
         @(posedge clk); #1;
      end
      checks++;
      if ({np_out, np_ready, np_busy, np_done} !== 4'b1100) begin
         errors++;
         $display("FAIL nopar_after: out,rdy,busy,done=%b expected 1100", {np_out, np_ready, np_busy, np_done});
      end
   endtask

   task automatic test_back_to_back();
      logic [21:0] exp;
      int          busy_cnt = 0;
      int          done_cnt = 0;
      exp = 22'b00011110011_01100001111;
      in_valid = 1'b1;
      in_data  = 8'h3C;
      @(posedge clk); #1;
      for (int k = 0; k < 22; k++) begin
         checks++;
         if (out !== exp[21-k]) begin
            errors++;
            $display("FAIL b2b_out[%0d]: out=%b expected %b", k, out, exp[21-k]);
         end
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) done_cnt++;
         if (k == 5) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_ready_mid: in_ready=%b expected 0", in_ready);
            end
         end
         if (k == 10) begin
            checks++;
            if ({in_ready, done} !== 2'b11) begin
               errors++;
               $display("FAIL b2b_stop1: ready,done=%b expected 11", {in_ready, done});
            end
            in_data = 8'hC3;
         end
         if (k == 11) in_valid = 1'b0;
         @(posedge clk); #1;
      end
      checks++;
      if (busy_cnt !== 22) begin
         errors++;
         $display("FAIL b2b_busy_cycles: got %0d expected 22", busy_cnt);
      end
      checks++;
      if (done_cnt !== 2) begin
         errors++;
         $display("FAIL b2b_done_pulses: got %0d expected 2", done_cnt);
      end
      checks++;
      if ({out, in_ready, busy, done} !== 4'b1100) begin
         errors++;
         $display("FAIL b2b_after: out,rdy,busy,done=%b expected 1100", {out, in_ready, busy, done});
      end
   endtask

   task automatic test_ignore_busy();
      logic [10:0] exp;
      exp = 11'b00110100111;
      in_valid = 1'b1;
      in_data  = 8'h96;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 11; k++) begin
         checks++;
         if (out !== exp[10-k]) begin
            errors++;
            $display("FAIL ignore_out[%0d]: out=%b expected %b", k, out, exp[10-k]);
         end
         if (k == 2) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL ignore_ready: in_ready=%b expected 0", in_ready);
            end
            in_valid = 1'b1;
            in_data  = 8'hFF;
         end
         if (k == 3) in_valid = 1'b0;
         if (k == 4) in_data = 8'h00;
         @(posedge clk); #1;
      end
      for (int c = 0; c < 2; c++) begin
         checks++;
         if ({out, in_ready, busy, done} !== 4'b1100) begin
            errors++;
            $display("FAIL ignore_idle[%0d]: out,rdy,busy,done=%b expected 1100", c, {out, in_ready, busy, done});
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mid_reset();
      in_valid = 1'b1;
      in_data  = 8'hA5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      checks++;
      if ({out, busy} !== 2'b01) begin
         errors++;
         $display("FAIL midrst_bit3: out,busy=%b expected 01", {out, busy});
      end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if ({out, in_ready, busy, done} !== 4'b1100) begin
         errors++;
         $display("FAIL midrst_async: out,rdy,busy,done=%b expected 1100", {out, in_ready, busy, done});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out, in_ready, busy, done} !== 4'b1100) begin
         errors++;
         $display("FAIL midrst_release: out,rdy,busy,done=%b expected 1100", {out, in_ready, busy, done});
      end
      send_frame(8'h81, 11'b01000000111, "midrst_81");
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_parity();
      test_no_parity();
      test_back_to_back();
      test_ignore_busy();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
